writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have one clock and one reset: the clock is CLK and the reset is RST_N, synchronous and active-low.
REQ-002 CLK  in  1  rising edge clocks every register in the block.
REQ-003 RST_N  in  1  synchronous active-low reset, sampled on rising CLK.
REQ-004 StallW  in  1  hold all W-stage registers.
REQ-005 FlushW  in  1  load a bubble into the W stage.
REQ-006 ValidM  in  1  M-stage slot holds a real instruction.
REQ-007 RegWriteM  in  1  instruction writes a GPR.
REQ-008 MemtoRegM  in  1  result is memory data (1) or ALU result (0).
REQ-009 WriteRegM  in  5  destination register number.
REQ-010 ALUOutM  in  32  ALU result or load address.
REQ-011 ReadDataM  in  32  raw data-memory word.
REQ-012 LoadTypeM  in  3  load width/sign code (see REQ-024).
REQ-013 A3  out  5  register-file write address.
REQ-014 WE3  out  1  register-file write enable.
REQ-015 WD3  out  32  register-file write data.
REQ-016 ValidW  out  1  W stage holds a real instruction.
REQ-017 RetireCount  out  32  count of instructions accepted into W.

Function
REQ-018 SHALL capture ValidM, RegWriteM, MemtoRegM, WriteRegM, ALUOutM, ReadDataM and LoadTypeM into W registers on a rising CLK when RST_N=1, FlushW=0 and StallW=0.
REQ-019 Priority on each rising edge SHALL be: reset > FlushW > StallW > capture.
REQ-020 Flush SHALL clear ValidW, RegWriteW and MemtoRegW to 0 and leave the data fields don't-care. FlushW with StallW both high SHALL flush.
REQ-021 Stall SHALL hold every W register, including RetireCount.
REQ-022 WE3 SHALL be ValidW & RegWriteW & (A3 != 0). A3 SHALL equal WriteRegW.
REQ-023 WD3 SHALL be combinational from W registers: ALUOutW when MemtoRegW=0, otherwise the aligned load value. Latency is one rising edge from M inputs to A3/WE3/WD3. The register file commits on the following falling edge of the same cycle.
REQ-024 Load alignment is little-endian, offset = ALUOutW[1:0]:
- 000 LW: whole word.
- 001 LB: byte at offset, sign-extended.
- 010 LBU: byte at offset, zero-extended.
- 011 LH: halfword selected by offset[1], sign-extended.
- 100 LHU: halfword selected by offset[1], zero-extended.
- Codes 101-111: treated as LW.
- Odd halfword offsets: bit 0 ignored, no exception.
REQ-025 RetireCount SHALL increment by 1 on each capture edge with ValidM=1, and SHALL wrap from 0xFFFFFFFF to 0x00000000.

Reset
REQ-026 With RST_N=0 at a rising edge, the block SHALL clear ValidW, RegWriteW, MemtoRegW, WriteRegW, ALUOutW, ReadDataW, LoadTypeW and RetireCount to 0. Outputs then read A3=0, WE3=0, WD3=0, ValidW=0, RetireCount=0.
REQ-027 Reset asserted mid-stall or mid-flush SHALL take precedence. The first capture SHALL occur on the first rising edge with RST_N=1.

Configuration
REQ-028 Macro WB_SUBWORD_LOAD_EN defined: REQ-024 alignment is compiled in.
REQ-029 Macro WB_SUBWORD_LOAD_EN undefined: LoadTypeM is accepted and ignored, no LoadTypeW register exists, and the load value is ReadDataW unmodified. All ports are identical in both builds.

Structure
REQ-030 Shared package mips_pkg SHALL hold the load-type encodings (LT_LW, LT_LB, LT_LBU, LT_LH, LT_LHU) and the data and register-address width constants.
REQ-031 Alignment SHALL be a combinational sub-module load_align (inputs: word, offset, load type; output: 32-bit value), instantiated only when WB_SUBWORD_LOAD_EN is defined.

Verification
REQ-032 Reset: RST_N=0 for 2 cycles with arbitrary inputs -> WE3=0, WD3=0, ValidW=0, RetireCount=0.
REQ-033 ALU path: ValidM=1, RegWriteM=1, MemtoRegM=0, WriteRegM=5, ALUOutM=0x12345678 -> after one edge A3=5, WE3=1, WD3=0x12345678, RetireCount=1. Same stimulus with WriteRegM=0 -> WE3=0.
REQ-034 Loads, ReadDataM=0x80FF7F01: LB at offset 1 -> 0x0000007F; LB at offset 3 -> 0xFFFFFF80; LBU at offset 2 -> 0x000000FF; LH at offset 2 -> 0xFFFF80FF; LHU at offset 3 -> 0x000080FF; code 111 -> 0x80FF7F01. Without the macro, every case -> 0x80FF7F01.
REQ-035 Stall/flush: hold StallW=1 for 3 cycles while M inputs change -> outputs and RetireCount unchanged. Then FlushW=1 with StallW=1 -> ValidW=0, WE3=0.
REQ-036 Wrap: force RetireCount to 0xFFFFFFFF and capture one valid instruction -> RetireCount=0. Capture with ValidM=0 -> count unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths, load-type encodings and the W-stage register bundle.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int LT_W       = 3;

    // Codes 101-111 are not named; consumers treat them as whole-word loads.
    typedef enum logic [LT_W-1:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } load_type_e;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] write_reg;
        logic [DATA_W-1:0]     alu_out;
        logic [DATA_W-1:0]     read_data;
    } w_regs_t;

endpackage

// File: rtl/load_align.sv
// Little-endian sub-word load extraction with sign/zero extension.
// Latency: purely combinational. Backpressure: none, no state.
// Handshake: none; output follows inputs in the same cycle.
module load_align
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [LT_W-1:0]   load_type,
    output logic [DATA_W-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // Misaligned halfwords simply drop offset bit 0.
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        value = word;
        case (load_type)
            LT_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  value = {24'd0, byte_sel};
            LT_LH:   value = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  value = {16'd0, half_sel};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MIPS write-back stage: W pipeline registers, load alignment (WB_SUBWORD_LOAD_EN), retire counter.
// Latency: one rising edge from M inputs to A3/WE3/WD3; outputs are combinational from W regs.
// Backpressure: StallW holds every W register; FlushW inserts a bubble and wins over StallW.
module writeback_stage
    import mips_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  StallW,
    input  logic                  FlushW,
    input  logic                  ValidM,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [DATA_W-1:0]     ALUOutM,
    input  logic [DATA_W-1:0]     ReadDataM,
    input  logic [LT_W-1:0]       LoadTypeM,
    output logic [REG_ADDR_W-1:0] A3,
    output logic                  WE3,
    output logic [DATA_W-1:0]     WD3,
    output logic                  ValidW,
    output logic [DATA_W-1:0]     RetireCount
);

    w_regs_t           w_q, w_d;
    logic [DATA_W-1:0] retire_count_q, retire_count_d;
    logic [DATA_W-1:0] load_val;
    logic              capture;

    assign capture = !FlushW && !StallW;

    always_comb begin
        w_d            = w_q;
        retire_count_d = retire_count_q;
        if (FlushW) begin
            // Bubble: only the control bits matter, data fields are left as they were.
            w_d.valid      = 1'b0;
            w_d.reg_write  = 1'b0;
            w_d.mem_to_reg = 1'b0;
        end else if (!StallW) begin
            w_d.valid      = ValidM;
            w_d.reg_write  = RegWriteM;
            w_d.mem_to_reg = MemtoRegM;
            w_d.write_reg  = WriteRegM;
            w_d.alu_out    = ALUOutM;
            w_d.read_data  = ReadDataM;
            if (ValidM) begin
                retire_count_d = retire_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            w_q            <= '0;
            retire_count_q <= '0;
        end else begin
            w_q            <= w_d;
            retire_count_q <= retire_count_d;
        end
    end

`ifdef WB_SUBWORD_LOAD_EN
    logic [LT_W-1:0] load_type_q, load_type_d;

    always_comb begin
        load_type_d = load_type_q;
        if (capture) begin
            load_type_d = LoadTypeM;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            load_type_q <= '0;
        end else begin
            load_type_q <= load_type_d;
        end
    end

    load_align u_load_align (
        .word      (w_q.read_data),
        .offset    (w_q.alu_out[1:0]),
        .load_type (load_type_q),
        .value     (load_val)
    );
`else
    // Word-only build: the load-type port is kept for a common interface.
    logic unused_load_type;
    assign unused_load_type = ^{LoadTypeM, capture};
    assign load_val         = w_q.read_data;
`endif

    assign A3          = w_q.write_reg;
    assign WE3         = w_q.valid && w_q.reg_write && (w_q.write_reg != '0);
    assign WD3         = w_q.mem_to_reg ? load_val : w_q.alu_out;
    assign ValidW      = w_q.valid;
    assign RetireCount = retire_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: vector table, hand-written stall/flush/wrap sequences, random run vs model.
module tb_writeback_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        StallW, FlushW, ValidM, RegWriteM, MemtoRegM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM, ReadDataM;
    logic [2:0]  LoadTypeM;
    logic [4:0]  A3;
    logic        WE3, ValidW;
    logic [31:0] WD3, RetireCount;

    int n_checks = 0;
    int n_errors = 0;

    writeback_stage dut (
        .CLK(CLK), .RST_N(RST_N), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
        .LoadTypeM(LoadTypeM), .A3(A3), .WE3(WE3), .WD3(WD3),
        .ValidW(ValidW), .RetireCount(RetireCount)
    );

    always #5 CLK = ~CLK;

    // Reference model: what the W stage should hold after each edge.
    logic        m_valid, m_rw, m_m2r;
    logic [4:0]  m_wreg;
    logic [31:0] m_alu, m_rd, m_cnt;
    logic [2:0]  m_lt;

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] lt);
        logic [31:0] v;
`ifdef WB_SUBWORD_LOAD_EN
        int sh;
        case (lt)
            3'd1, 3'd2: begin
                sh = 8 * int'(off);
                v  = (w >> sh) & 32'hFF;
                if (lt == 3'd1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            3'd3, 3'd4: begin
                sh = (int'(off) / 2) * 16;
                v  = (w >> sh) & 32'hFFFF;
                if (lt == 3'd3 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
`else
        v = w + 32'(off & 2'd0) + 32'(lt & 3'd0);
`endif
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (!RST_N) begin
            m_valid = 0; m_rw = 0; m_m2r = 0; m_wreg = 0;
            m_alu = 0; m_rd = 0; m_lt = 0; m_cnt = 0;
        end else if (FlushW) begin
            m_valid = 0; m_rw = 0; m_m2r = 0;
        end else if (!StallW) begin
            m_valid = ValidM; m_rw = RegWriteM; m_m2r = MemtoRegM; m_wreg = WriteRegM;
            m_alu = ALUOutM; m_rd = ReadDataM; m_lt = LoadTypeM;
            if (ValidM) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".A3"}, 32'(A3), 32'(m_wreg));
        check({tag, ".WE3"}, 32'(WE3), 32'(m_valid && m_rw && (m_wreg != 0)));
        check({tag, ".ValidW"}, 32'(ValidW), 32'(m_valid));
        check({tag, ".RetireCount"}, RetireCount, m_cnt);
        if (m_valid)
            check({tag, ".WD3"}, WD3, m_m2r ? ref_load(m_rd, m_alu[1:0], m_lt) : m_alu);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] wr,
                         input logic [31:0] alu, input logic [31:0] rd, input logic [2:0] lt);
        ValidM = v; RegWriteM = rw; MemtoRegM = m2r; WriteRegM = wr;
        ALUOutM = alu; ReadDataM = rd; LoadTypeM = lt;
    endtask

    typedef struct {
        string       name;
        logic        v, rw, m2r;
        logic [4:0]  wr;
        logic [31:0] alu, rd;
        logic [2:0]  lt;
        logic [4:0]  exp_a3;
        logic        exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] cnt_before;
        logic [31:0] ld = 32'h80FF_7F01;

        vecs.push_back('{"alu_r5",   1, 1, 0, 5'd5, 32'h1234_5678, 32'h0, 3'd0, 5'd5, 1, 32'h1234_5678});
        vecs.push_back('{"alu_r0",   1, 1, 0, 5'd0, 32'h1234_5678, 32'h0, 3'd0, 5'd0, 0, 32'h1234_5678});
        vecs.push_back('{"alu_nowr", 1, 0, 0, 5'd9, 32'hCAFE_0001, 32'h0, 3'd0, 5'd9, 0, 32'hCAFE_0001});
`ifdef WB_SUBWORD_LOAD_EN
        vecs.push_back('{"lb_off1",  1, 1, 1, 5'd7, 32'h0000_1001, ld, 3'd1, 5'd7, 1, 32'h0000_007F});
        vecs.push_back('{"lb_off3",  1, 1, 1, 5'd7, 32'h0000_1003, ld, 3'd1, 5'd7, 1, 32'hFFFF_FF80});
        vecs.push_back('{"lbu_off2", 1, 1, 1, 5'd7, 32'h0000_1002, ld, 3'd2, 5'd7, 1, 32'h0000_00FF});
        vecs.push_back('{"lh_off2",  1, 1, 1, 5'd7, 32'h0000_1002, ld, 3'd3, 5'd7, 1, 32'hFFFF_80FF});
        vecs.push_back('{"lhu_off3", 1, 1, 1, 5'd7, 32'h0000_1003, ld, 3'd4, 5'd7, 1, 32'h0000_80FF});
        vecs.push_back('{"lh_off1",  1, 1, 1, 5'd7, 32'h0000_1001, ld, 3'd3, 5'd7, 1, 32'h0000_7F01});
        vecs.push_back('{"lt111",    1, 1, 1, 5'd7, 32'h0000_1001, ld, 3'd7, 5'd7, 1, 32'h80FF_7F01});
        vecs.push_back('{"lw_off0",  1, 1, 1, 5'd7, 32'h0000_1000, ld, 3'd0, 5'd7, 1, 32'h80FF_7F01});
`else
        vecs.push_back('{"lb_off1",  1, 1, 1, 5'd7, 32'h0000_1001, ld, 3'd1, 5'd7, 1, 32'h80FF_7F01});
        vecs.push_back('{"lb_off3",  1, 1, 1, 5'd7, 32'h0000_1003, ld, 3'd1, 5'd7, 1, 32'h80FF_7F01});
        vecs.push_back('{"lbu_off2", 1, 1, 1, 5'd7, 32'h0000_1002, ld, 3'd2, 5'd7, 1, 32'h80FF_7F01});
        vecs.push_back('{"lh_off2",  1, 1, 1, 5'd7, 32'h0000_1002, ld, 3'd3, 5'd7, 1, 32'h80FF_7F01});
        vecs.push_back('{"lhu_off3", 1, 1, 1, 5'd7, 32'h0000_1003, ld, 3'd4, 5'd7, 1, 32'h80FF_7F01});
        vecs.push_back('{"lt111",    1, 1, 1, 5'd7, 32'h0000_1001, ld, 3'd7, 5'd7, 1, 32'h80FF_7F01});
`endif

        // Reset for two cycles with arbitrary inputs present.
        RST_N = 0; StallW = 1; FlushW = 0;
        drive(1, 1, 1, 5'd3, 32'hDEAD_BEEF, 32'h1111_2222, 3'd1);
        tick();
        StallW = 0;
        tick();
        check("rst.WE3", 32'(WE3), 32'd0);
        check("rst.WD3", WD3, 32'd0);
        check("rst.A3", 32'(A3), 32'd0);
        check("rst.ValidW", 32'(ValidW), 32'd0);
        check("rst.RetireCount", RetireCount, 32'd0);

        // First capture happens on the first edge with reset released.
        RST_N = 1;
        cnt_before = 0;
        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].wr, vecs[i].alu, vecs[i].rd, vecs[i].lt);
            tick();
            check({vecs[i].name, ".A3"}, 32'(A3), 32'(vecs[i].exp_a3));
            check({vecs[i].name, ".WE3"}, 32'(WE3), 32'(vecs[i].exp_we));
            check({vecs[i].name, ".WD3"}, WD3, vecs[i].exp_wd);
            check({vecs[i].name, ".RetireCount"}, RetireCount, cnt_before + 1);
            cnt_before = cnt_before + 1;
        end

        // Stall for three cycles with changing M inputs: nothing moves.
        drive(1, 1, 0, 5'd12, 32'h0BAD_F00D, 32'h0, 3'd0);
        tick();
        StallW = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 5'(i + 20), $urandom, $urandom, 3'(i));
            tick();
            check("stall.A3", 32'(A3), 32'd12);
            check("stall.WD3", WD3, 32'h0BAD_F00D);
            check("stall.WE3", 32'(WE3), 32'd1);
            check("stall.RetireCount", RetireCount, m_cnt);
        end
        FlushW = 1;
        tick();
        check("flush_stall.ValidW", 32'(ValidW), 32'd0);
        check("flush_stall.WE3", 32'(WE3), 32'd0);
        check("flush_stall.RetireCount", RetireCount, m_cnt);
        StallW = 0; FlushW = 0;

        // Reset while stalled and flushing still clears the counter.
        RST_N = 0; StallW = 1; FlushW = 1;
        tick();
        check("rst_mid.RetireCount", RetireCount, 32'd0);
        check("rst_mid.ValidW", 32'(ValidW), 32'd0);
        RST_N = 1; StallW = 0; FlushW = 0;

        // Counter wrap: preload 0xFFFFFFFF through the next-state net.
        drive(0, 0, 0, 5'd1, 32'h0, 32'h0, 3'd0);
        force dut.retire_count_d = 32'hFFFF_FFFF;
        tick();
        release dut.retire_count_d;
        m_cnt = 32'hFFFF_FFFF;
        check("wrap.preload", RetireCount, 32'hFFFF_FFFF);
        drive(1, 1, 0, 5'd2, 32'h0000_0042, 32'h0, 3'd0);
        tick();
        check("wrap.RetireCount", RetireCount, 32'h0000_0000);
        drive(0, 1, 0, 5'd2, 32'h0000_0043, 32'h0, 3'd0);
        tick();
        check("novalid.RetireCount", RetireCount, 32'h0000_0000);
        check("novalid.WE3", 32'(WE3), 32'd0);

        // Random run against the model.
        for (int i = 0; i < 400; i++) begin
            RST_N  = ($urandom_range(0, 49) != 0);
            StallW = ($urandom_range(0, 4) == 0);
            FlushW = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), $urandom, $urandom, 3'($urandom_range(0, 7)));
            tick();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
